// File: rtl/seq_div_pkg.sv
// Shared arithmetic-unit definitions: FSM encoding common to the multiplier
// and divider, counter sizing and the default datapath width.
package seq_div_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ZDIV = 2'd2
   } state_e;

   // Counter must reach WIDTH itself, hence one bit beyond clog2.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only if it did not go negative.
module seq_div_step
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] prem_i,
   input  logic             dbit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] prem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // WIDTH+1 bits: the shifted remainder may carry out of WIDTH bits.
   assign shifted = {prem_i, dbit_i};
   assign trial   = shifted - {1'b0, divisor_i};

   always_comb begin
      qbit_o = ~trial[WIDTH];
      prem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with the
// same enable/ready handshake as the sequential multiplier.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             enable,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             ready,
   output logic             div_by_zero
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] MAXC = CW'(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             ready_q, ready_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;

   seq_div_step #(.WIDTH(WIDTH)) u_step (
      .prem_i    (prem_q),
      .dbit_i    (dvd_q[WIDTH-1]),
      .divisor_i (dsr_q),
      .prem_o    (step_rem),
      .qbit_o    (step_qbit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = (B == '0) ? ZDIV : BUSY;
         BUSY:    if (cnt_q == LAST) state_d = IDLE;
         ZDIV:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The dividend register doubles as the quotient: quotient bits enter at
   // the LSB as dividend bits leave at the MSB.
   always_comb begin
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ready_d = ready_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               dvd_d   = A;
               dsr_d   = B;
               prem_d  = '0;
               cnt_d   = '0;
               ready_d = 1'b0;
            end
         end
         BUSY: begin
            dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
            prem_d = step_rem;
            cnt_d  = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               quot_d  = {dvd_q[WIDTH-2:0], step_qbit};
               rem_d   = step_rem;
               dbz_d   = 1'b0;
               ready_d = 1'b1;
            end
         end
         ZDIV: begin
            quot_d  = '1;
            rem_d   = dvd_q;
            dbz_d   = 1'b1;
            ready_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign quot        = quot_q;
   assign rem         = rem_q;
   assign ready       = ready_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (WIDTH=8): hand-computed results, latency,
// hold behaviour, divide-by-zero, async reset, back-to-back and random invariants.
module tb_seq_div;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] A, B;
   logic       enable;
   logic [7:0] quot, rem;
   logic       ready, div_by_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seq_div #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .A           (A),
      .B           (B),
      .enable      (enable),
      .quot        (quot),
      .rem         (rem),
      .ready       (ready),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present operands, hold enable for the accepting edge, count edges to ready.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int n);
      @(negedge clk);
      A = a; B = b; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int eq, input int er, input int ez, input int elat);
      int n;
      do_op(a, b, n);
      chk({tag, "_lat"}, n, elat);
      chk({tag, "_q"}, quot, eq);
      chk({tag, "_r"}, rem, er);
      chk({tag, "_dbz"}, div_by_zero, ez);
   endtask

   initial begin
      int n, stable, mid_q, mid_r, t_acc, t_prev, ok;
      logic [7:0] ra, rb;

      rst = 1'b0; enable = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_q", quot, 0);
      chk("rst_r", rem, 0);
      chk("rst_ready", ready, 1);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b1;

      run_op("d100_7", 8'd100, 8'd7, 14, 2, 0, 8);
      stable = 1;
      repeat (20) begin
         @(posedge clk); #1;
         if (quot !== 8'd14 || rem !== 8'd2 || ready !== 1'b1) stable = 0;
      end
      chk("hold20", stable, 1);

      run_op("d255_255", 8'd255, 8'd255, 1, 0, 0, 8);
      run_op("d5_16", 8'd5, 8'd16, 0, 5, 0, 8);
      run_op("d255_1", 8'd255, 8'd1, 255, 0, 0, 8);
      run_op("d0_9", 8'd0, 8'd9, 0, 0, 0, 8);

      run_op("z200", 8'd200, 8'd0, 255, 200, 1, 1);
      run_op("d39_5", 8'd39, 8'd5, 7, 4, 0, 8);

      // Mid-operation request and operand changes must be ignored.
      @(negedge clk);
      A = 8'd100; B = 8'd7; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      chk("ign_busy", ready, 0);
      n = 0; mid_q = -1; mid_r = -1;
      while (ready !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 3) begin A = 8'd9; B = 8'd3; enable = 1'b1; end
         else if (n == 4) begin enable = 1'b0; A = 8'd50; B = 8'd1; end
         if (n == 5) begin mid_q = quot; mid_r = rem; end
      end
      chk("ign_lat", n, 8);
      chk("ign_midq", mid_q, 7);
      chk("ign_midr", mid_r, 4);
      chk("ign_q", quot, 14);
      chk("ign_r", rem, 2);
      @(posedge clk); #1;
      chk("ign_noacc", ready, 1);

      // Asynchronous reset between edges, mid-operation.
      @(negedge clk);
      A = 8'd255; B = 8'd13; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_q", quot, 0);
      chk("arst_r", rem, 0);
      chk("arst_ready", ready, 1);
      chk("arst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b1;
      run_op("d255_13", 8'd255, 8'd13, 19, 8, 0, 8);

      // Enable held high: accept every WIDTH+1 edges.
      @(negedge clk);
      A = 8'd77; B = 8'd6; enable = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (ready !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
         t_acc = cyc;
         n = 0;
         while (ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
         chk("b2b_lat", n, 8);
         chk("b2b_q", quot, 12);
         chk("b2b_r", rem, 5);
         if (k > 0) chk("b2b_period", t_acc - t_prev, 9);
         t_prev = t_acc;
      end
      @(negedge clk);
      enable = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(255, 0));
         rb = 8'($urandom_range(255, 1));
         do_op(ra, rb, n);
         ok = ((16'(quot) * 16'(rb) + 16'(rem)) == 16'(ra)) && (rem < rb) && (n == 8);
         if (ok == 0) $display("rnd vector a=%0d b=%0d q=%0d r=%0d lat=%0d", ra, rb, quot, rem, n);
         chk("rnd_inv", ok, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
